// File: rtl/mem_tid_arbiter_pkg.sv
// Shared types and width helpers for the memory transaction-ID arbiter.
package mem_tid_arbiter_pkg;

   localparam int unsigned CVA6ConfigMemTidWidth = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   function automatic int unsigned num_tid(input int unsigned tid_width);
      return 32'd1 << tid_width;
   endfunction

   // Counter must be able to hold NumTid itself, hence one extra bit.
   function automatic int unsigned cnt_width(input int unsigned tid_width);
      return tid_width + 1;
   endfunction

   function automatic int unsigned sel_width(input int unsigned num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/mem_tid_arbiter_rr.sv
// Round-robin pick among requesters, starting the search at ptr_i and wrapping.
module rr_arbiter #(
   parameter int unsigned NumReq   = 2,
   parameter int unsigned SelWidth = 1
) (
   input  logic [NumReq-1:0]   req_i,
   input  logic [SelWidth-1:0] ptr_i,
   output logic                valid_o,
   output logic [SelWidth-1:0] idx_o
);

   logic                any_req;
   logic                upper_req;
   logic [SelWidth-1:0] lowest_any;
   logic [SelWidth-1:0] lowest_upper;

   // Lowest request at or above the pointer wins; otherwise wrap to the lowest overall.
   always_comb begin
      any_req      = 1'b0;
      upper_req    = 1'b0;
      lowest_any   = '0;
      lowest_upper = '0;
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            any_req    = 1'b1;
            lowest_any = SelWidth'(i);
            if (i >= int'(ptr_i)) begin
               upper_req    = 1'b1;
               lowest_upper = SelWidth'(i);
            end
         end
      end
      valid_o = any_req;
      idx_o   = upper_req ? lowest_upper : lowest_any;
   end

endmodule

// File: rtl/mem_tid_arbiter.sv
// Arbitrates cache-miss requesters onto the NoC, tagging each request with a free
// transaction ID and routing single-beat responses back to the ID's owner.
module mem_tid_arbiter
   import mem_tid_arbiter_pkg::*;
#(
   parameter int unsigned NumReq      = 2,
   parameter int unsigned MemTidWidth = CVA6ConfigMemTidWidth,
   localparam int unsigned NumTid     = num_tid(MemTidWidth),
   localparam int unsigned SelWidth   = sel_width(NumReq),
   localparam int unsigned CntWidth   = cnt_width(MemTidWidth)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumReq-1:0]      req_valid_i,
   output logic [NumReq-1:0]      req_ready_o,
   input  logic                   flush_i,
   output logic                   mem_req_valid_o,
   input  logic                   mem_req_ready_i,
   output logic [SelWidth-1:0]    mem_req_sel_o,
   output logic [MemTidWidth-1:0] mem_req_tid_o,
   input  logic                   mem_rsp_valid_i,
   input  logic [MemTidWidth-1:0] mem_rsp_tid_i,
   output logic [NumReq-1:0]      rsp_valid_o,
   output logic [CntWidth-1:0]    outstanding_o,
   output logic                   idle_o,
   output logic                   err_o
);

   arb_state_e           state_q;
   logic [SelWidth-1:0]    sel_q;
   logic [SelWidth-1:0]    rr_ptr_q;
   logic [SelWidth-1:0]    rr_winner;
   logic [SelWidth-1:0]    next_ptr;
   logic                   rr_valid;
   logic [MemTidWidth-1:0] tid_q;
   logic [MemTidWidth-1:0] free_tid;
   logic                   free_valid;
   logic [NumTid-1:0]      busy_q;
   logic [SelWidth-1:0]    owner_q [NumTid];
   logic                   err_q;
   logic                   handshake;
   logic                   rsp_hit;
   logic                   rsp_err;

   rr_arbiter #(
      .NumReq   (NumReq),
      .SelWidth (SelWidth)
   ) u_rr_arbiter (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .valid_o (rr_valid),
      .idx_o   (rr_winner)
   );

   // Only the registered bitmap is searched, so an ID freed this cycle waits a cycle.
   always_comb begin
      free_valid = 1'b0;
      free_tid   = '0;
      for (int i = int'(NumTid) - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_valid = 1'b1;
            free_tid   = MemTidWidth'(i);
         end
      end
   end

   always_comb begin
      outstanding_o = '0;
      for (int i = 0; i < int'(NumTid); i++) begin
         outstanding_o = outstanding_o + CntWidth'(busy_q[i]);
      end
   end

   assign handshake = (state_q == HOLD) && mem_req_ready_i;
   assign rsp_hit   = mem_rsp_valid_i && busy_q[mem_rsp_tid_i];
   assign rsp_err   = mem_rsp_valid_i && !busy_q[mem_rsp_tid_i];
   assign next_ptr  = (int'(sel_q) == int'(NumReq) - 1) ? '0 : sel_q + 1'b1;

   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (handshake) begin
         req_ready_o[sel_q] = 1'b1;
      end
      if (rsp_hit) begin
         rsp_valid_o[owner_q[mem_rsp_tid_i]] = 1'b1;
      end
   end

   assign mem_req_valid_o = (state_q == HOLD);
   assign mem_req_sel_o   = sel_q;
   assign mem_req_tid_o   = tid_q;
   assign idle_o          = (state_q == IDLE) && (outstanding_o == '0);
   assign err_o           = err_q;

   // Flush wins over a new grant in IDLE but never aborts a request already on the bus.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         tid_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush_i) begin
                  state_q <= DRAIN;
               end else if (rr_valid && free_valid) begin
                  sel_q   <= rr_winner;
                  tid_q   <= free_tid;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (mem_req_ready_i) begin
                  rr_ptr_q <= next_ptr;
                  state_q  <= flush_i ? DRAIN : IDLE;
               end
            end
            DRAIN: begin
               if ((outstanding_o == '0) && !flush_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < int'(NumTid); i++) begin
            owner_q[i] <= '0;
         end
      end else begin
         if (rsp_hit) begin
            busy_q[mem_rsp_tid_i] <= 1'b0;
         end
         if (handshake) begin
            busy_q[tid_q]  <= 1'b1;
            owner_q[tid_q] <= sel_q;
         end
         if (rsp_err) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_tid_arbiter.sv
// Self-checking bench for mem_tid_arbiter: table vectors, directed corner sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_tid_arbiter;

   localparam int NumReq      = 2;
   localparam int MemTidWidth = 2;
   localparam int NumTid      = 4;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [1:0] req_valid_i;
   logic [1:0] req_ready_o;
   logic       flush_i;
   logic       mem_req_valid_o;
   logic       mem_req_ready_i;
   logic       mem_req_sel_o;
   logic [1:0] mem_req_tid_o;
   logic       mem_rsp_valid_i;
   logic [1:0] mem_rsp_tid_i;
   logic [1:0] rsp_valid_o;
   logic [2:0] outstanding_o;
   logic       idle_o;
   logic       err_o;

   int vectors     = 0;
   int miscompares = 0;

   mem_tid_arbiter #(
      .NumReq      (NumReq),
      .MemTidWidth (MemTidWidth)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .flush_i         (flush_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_sel_o   (mem_req_sel_o),
      .mem_req_tid_o   (mem_req_tid_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_tid_i   (mem_rsp_tid_i),
      .rsp_valid_o     (rsp_valid_o),
      .outstanding_o   (outstanding_o),
      .idle_o          (idle_o),
      .err_o           (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0] req;
      logic       rdy;
      logic       rspv;
      logic [1:0] rspt;
      logic       flush;
      logic       mv;
      logic       sel;
      logic [1:0] tid;
      logic [1:0] rr;
      logic [1:0] rv;
      logic [2:0] outs;
      logic       idle;
   } vec_t;

   vec_t tbl [13];

   // Reference model: plain arrays describing which IDs are held and by whom.
   bit m_busy  [NumTid];
   int m_owner [NumTid];
   int m_ptr;
   bit m_hold;
   bit m_drain;
   int m_sel;
   int m_tid;
   bit m_err;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] req, input logic rdy, input logic rspv,
                                input logic [1:0] rspt, input logic flush);
      req_valid_i     = req;
      mem_req_ready_i = rdy;
      mem_rsp_valid_i = rspv;
      mem_rsp_tid_i   = rspt;
      flush_i         = flush;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic doReset();
      rst_i = 1'b1;
      applyStimulus(2'b11, 1'b1, 1'b1, 2'd0, 1'b0);
      checkOutput("reset.mem_req_valid", mem_req_valid_o, 0);
      checkOutput("reset.req_ready", req_ready_o, 0);
      checkOutput("reset.rsp_valid", rsp_valid_o, 0);
      checkOutput("reset.outstanding", outstanding_o, 0);
      checkOutput("reset.idle", idle_o, 1);
      checkOutput("reset.err", err_o, 0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      applyStimulus(2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
   endtask

   function automatic int modelCount();
      int c = 0;
      for (int i = 0; i < NumTid; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NumTid; i++) begin
         m_busy[i]  = 1'b0;
         m_owner[i] = 0;
      end
      m_ptr = 0; m_hold = 0; m_drain = 0; m_sel = 0; m_tid = 0; m_err = 0;
   endtask

   // Advance the model across one clock edge given the inputs held during the cycle.
   task automatic modelStep(input logic [1:0] req, input logic rdy, input logic rspv,
                            input logic [1:0] rspt, input logic flush);
      bit nbusy [NumTid];
      int cnt;
      int lowfree;
      int winner;
      cnt = modelCount();
      for (int i = 0; i < NumTid; i++) nbusy[i] = m_busy[i];
      if (rspv) begin
         if (m_busy[rspt]) nbusy[rspt] = 1'b0;
         else m_err = 1'b1;
      end
      if (m_hold) begin
         if (rdy) begin
            nbusy[m_tid]   = 1'b1;
            m_owner[m_tid] = m_sel;
            m_ptr          = (m_sel + 1) % NumReq;
            m_hold         = 1'b0;
            m_drain        = flush;
         end
      end else if (m_drain) begin
         if (cnt == 0 && !flush) m_drain = 1'b0;
      end else if (flush) begin
         m_drain = 1'b1;
      end else begin
         lowfree = -1;
         for (int i = NumTid - 1; i >= 0; i--) if (!m_busy[i]) lowfree = i;
         winner = -1;
         for (int k = NumReq - 1; k >= 0; k--) if (req[(m_ptr + k) % NumReq]) winner = (m_ptr + k) % NumReq;
         if (winner >= 0 && lowfree >= 0) begin
            m_sel  = winner;
            m_tid  = lowfree;
            m_hold = 1'b1;
         end
      end
      for (int i = 0; i < NumTid; i++) m_busy[i] = nbusy[i];
   endtask

   initial begin
      logic [1:0] rq;
      logic       rdy;
      logic       rspv;
      logic [1:0] rspt;
      logic       fl;
      int         flush_left;
      int         busy_list [$];
      logic [1:0] exp_rv;

      // Both requesters hammering with the NoC always ready: four grants, stall, refill.
      tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 3'd0, 1'b1};
      tbl[1]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'b01, 2'b00, 3'd0, 1'b0};
      tbl[2]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 3'd1, 1'b0};
      tbl[3]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 2'b10, 2'b00, 3'd1, 1'b0};
      tbl[4]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 3'd2, 1'b0};
      tbl[5]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2, 2'b01, 2'b00, 3'd2, 1'b0};
      tbl[6]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 3'd3, 1'b0};
      tbl[7]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd3, 2'b10, 2'b00, 3'd3, 1'b0};
      tbl[8]  = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 3'd4, 1'b0};
      tbl[9]  = '{2'b11, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'b01, 3'd4, 1'b0};
      tbl[10] = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 3'd3, 1'b0};
      tbl[11] = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2, 2'b01, 2'b00, 3'd3, 1'b0};
      tbl[12] = '{2'b11, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'b00, 3'd4, 1'b0};

      $display("[TB] table vectors");
      doReset();
      for (int i = 0; i < 13; i++) begin
         applyStimulus(tbl[i].req, tbl[i].rdy, tbl[i].rspv, tbl[i].rspt, tbl[i].flush);
         checkOutput($sformatf("tbl%0d.mem_req_valid", i), mem_req_valid_o, tbl[i].mv);
         if (tbl[i].mv) begin
            checkOutput($sformatf("tbl%0d.sel", i), mem_req_sel_o, tbl[i].sel);
            checkOutput($sformatf("tbl%0d.tid", i), mem_req_tid_o, tbl[i].tid);
         end
         checkOutput($sformatf("tbl%0d.req_ready", i), req_ready_o, tbl[i].rr);
         checkOutput($sformatf("tbl%0d.rsp_valid", i), rsp_valid_o, tbl[i].rv);
         checkOutput($sformatf("tbl%0d.outstanding", i), outstanding_o, tbl[i].outs);
         checkOutput($sformatf("tbl%0d.idle", i), idle_o, tbl[i].idle);
         checkOutput($sformatf("tbl%0d.err", i), err_o, 0);
         nextCycle();
      end

      $display("[TB] NoC back-pressure in HOLD");
      doReset();
      applyStimulus(2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
      checkOutput("bp.pre_valid", mem_req_valid_o, 0);
      nextCycle();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
         checkOutput("bp.hold_valid", mem_req_valid_o, 1);
         checkOutput("bp.hold_sel", mem_req_sel_o, 0);
         checkOutput("bp.hold_tid", mem_req_tid_o, 0);
         checkOutput("bp.hold_ready", req_ready_o, 0);
         nextCycle();
      end
      applyStimulus(2'b01, 1'b1, 1'b0, 2'd0, 1'b0);
      checkOutput("bp.pulse", req_ready_o, 2'b01);
      checkOutput("bp.pulse_tid", mem_req_tid_o, 0);
      nextCycle();
      applyStimulus(2'b00, 1'b1, 1'b0, 2'd0, 1'b0);
      checkOutput("bp.after_ready", req_ready_o, 0);
      checkOutput("bp.after_valid", mem_req_valid_o, 0);
      checkOutput("bp.after_outstanding", outstanding_o, 1);

      $display("[TB] response on a free ID");
      doReset();
      applyStimulus(2'b00, 1'b0, 1'b1, 2'd3, 1'b0);
      checkOutput("stray.rsp_valid", rsp_valid_o, 0);
      nextCycle();
      applyStimulus(2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
      checkOutput("stray.err", err_o, 1);
      checkOutput("stray.outstanding", outstanding_o, 0);
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("stray.err_sticky", err_o, 1);

      $display("[TB] flush with outstanding IDs");
      doReset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
         nextCycle();
      end
      applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 1'b1);
      checkOutput("flush.outstanding", outstanding_o, 2);
      nextCycle();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 1'b1);
         checkOutput("flush.no_grant", mem_req_valid_o, 0);
         checkOutput("flush.no_ready", req_ready_o, 0);
         checkOutput("flush.not_idle", idle_o, 0);
         nextCycle();
      end
      applyStimulus(2'b11, 1'b1, 1'b1, 2'd0, 1'b1);
      checkOutput("flush.rsp0", rsp_valid_o, 2'b01);
      nextCycle();
      applyStimulus(2'b11, 1'b1, 1'b1, 2'd1, 1'b1);
      checkOutput("flush.rsp1", rsp_valid_o, 2'b10);
      nextCycle();
      applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 1'b1);
      checkOutput("flush.drained_cnt", outstanding_o, 0);
      checkOutput("flush.still_flushing", idle_o, 0);
      nextCycle();
      applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
      checkOutput("flush.release_cycle", idle_o, 0);
      checkOutput("flush.release_valid", mem_req_valid_o, 0);
      nextCycle();
      applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
      checkOutput("flush.idle", idle_o, 1);
      nextCycle();
      checkOutput("flush.resume_valid", mem_req_valid_o, 1);
      checkOutput("flush.resume_sel", mem_req_sel_o, 0);
      checkOutput("flush.resume_tid", mem_req_tid_o, 0);

      $display("[TB] async reset in HOLD");
      doReset();
      applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
      nextCycle();
      nextCycle();
      applyStimulus(2'b11, 1'b0, 1'b0, 2'd0, 1'b0);
      nextCycle();
      checkOutput("arst.hold_valid", mem_req_valid_o, 1);
      checkOutput("arst.hold_sel", mem_req_sel_o, 1);
      checkOutput("arst.hold_tid", mem_req_tid_o, 1);
      checkOutput("arst.hold_outstanding", outstanding_o, 1);
      #1 rst_i = 1'b1;
      #1;
      checkOutput("arst.valid_drop", mem_req_valid_o, 0);
      checkOutput("arst.outstanding", outstanding_o, 0);
      checkOutput("arst.idle", idle_o, 1);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      applyStimulus(2'b11, 1'b1, 1'b0, 2'd0, 1'b0);
      nextCycle();
      checkOutput("arst.next_valid", mem_req_valid_o, 1);
      checkOutput("arst.next_sel", mem_req_sel_o, 0);
      checkOutput("arst.next_tid", mem_req_tid_o, 0);

      $display("[TB] randomized run against reference model");
      doReset();
      modelReset();
      rq = 2'b00;
      flush_left = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int r = 0; r < NumReq; r++) begin
            if (!rq[r] && $urandom_range(0, 3) == 0) rq[r] = 1'b1;
         end
         rdy = ($urandom_range(0, 2) != 0);
         if (flush_left == 0 && $urandom_range(0, 39) == 0) flush_left = int'($urandom_range(1, 8));
         fl = (flush_left > 0);
         if (flush_left > 0) flush_left--;
         busy_list.delete();
         for (int i = 0; i < NumTid; i++) if (m_busy[i]) busy_list.push_back(i);
         rspv = 1'b0;
         rspt = 2'($urandom_range(0, 3));
         if (busy_list.size() > 0 && $urandom_range(0, 2) == 0) begin
            rspv = 1'b1;
            rspt = 2'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
         end
         applyStimulus(rq, rdy, rspv, rspt, fl);

         exp_rv = 2'b00;
         if (rspv && m_busy[rspt]) exp_rv[m_owner[rspt]] = 1'b1;
         checkOutput("rand.mem_req_valid", mem_req_valid_o, m_hold);
         if (m_hold) begin
            checkOutput("rand.sel", mem_req_sel_o, m_sel);
            checkOutput("rand.tid", mem_req_tid_o, m_tid);
         end
         checkOutput("rand.req_ready", req_ready_o, (m_hold && rdy) ? (1 << m_sel) : 0);
         checkOutput("rand.rsp_valid", rsp_valid_o, exp_rv);
         checkOutput("rand.outstanding", outstanding_o, modelCount());
         checkOutput("rand.idle", idle_o, (!m_hold && !m_drain && modelCount() == 0));
         checkOutput("rand.err", err_o, m_err);

         if (m_hold && rdy) rq[m_sel] = 1'b0;
         modelStep(req_valid_i, rdy, rspv, rspt, fl);
         nextCycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
